// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage 8-bit RISC-V core.
// Covers the hazards forwarding cannot: load-use stalls, taken-branch
// flushes, multi-cycle data-memory waits and HALT. It drives the pipeline
// register enables/flushes and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  input  logic             exmem_mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic             pc_sel_branch,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // The wait counter only needs to reach MEM_TIMEOUT, which is at most 255.
  localparam logic [7:0]       TIMEOUT_VAL = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;

  logic mem_stall;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  // Hazard conditions seen this cycle; x0 never creates a dependency.
  always_comb begin
    mem_stall = exmem_mem_req & ~dmem_ready;
    rs1_hit   = id_use_rs1 & (idex_rd == id_rs1);
    rs2_hit   = id_use_rs2 & (idex_rd == id_rs2);
    load_use  = idex_memread & (idex_rd != 5'd0) & (rs1_hit | rs2_hit);
  end

  // Next-state and pipeline controls, decided by state then hazard priority.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    mem_err_d     = mem_err_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_write    = 1'b1;
    idex_flush    = 1'b0;
    exmem_write   = 1'b1;
    memwb_flush   = 1'b0;
    pc_sel_branch = 1'b0;
    halted        = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          // The instruction in MEM is stuck, so everything behind it freezes
          // and a bubble goes into WB.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_d      = 8'd1;
          stall_inc   = 1'b1;
        end else if (ex_halt) begin
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = ST_HALT;
        end else if (ex_branch_taken) begin
          // The squashed younger instruction cannot cause a load-use stall.
          pc_sel_branch = 1'b1;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          flush_inc     = 1'b1;
        end else if (load_use) begin
          // One bubble is enough; forwarding covers the following cycle.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          // Release cycle: hazards in the frozen stages are judged next cycle.
          state_d = ST_RUN;
          wait_d  = 8'd0;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
          if (wait_q == TIMEOUT_VAL) begin
            mem_err_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            wait_d    = wait_q + 8'd1;
            stall_inc = 1'b1;
          end
        end
      end

      default: begin
        // HALT, and the illegal encoding which is folded into HALT. The back
        // end keeps draining; only reset leaves this state.
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        halted     = 1'b1;
        state_d    = ST_HALT;
      end
    endcase

    // While reset is held the pipeline runs freely regardless of inputs.
    if (rst) begin
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idex_write    = 1'b1;
      idex_flush    = 1'b0;
      exmem_write   = 1'b1;
      memwb_flush   = 1'b0;
      pc_sel_branch = 1'b0;
      halted        = 1'b0;
    end
  end

  // Sequencer state, memory wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage 8-bit RISC-V core. It sits beside the operand-forwarding logic.
- Resolves hazards that forwarding cannot cover: load-use stalls, taken-branch flushes, multi-cycle data-memory waits and HALT.
- Drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps saturating stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before a bus error is declared; legal range 1..255.
- CNT_W, 16: width of the stall and flush performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- idex_memread  in  1  instruction in EX is a load.
- idex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- ex_halt  in  1  HALT/ECALL present in EX.
- exmem_mem_req  in  1  instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_write  out  1  ID/EX register enable.
- idex_flush  out  1  load bubble (all controls zero) into ID/EX.
- exmem_write  out  1  EX/MEM register enable.
- memwb_flush  out  1  load bubble into MEM/WB.
- pc_sel_branch  out  1  select branch target for the next PC.
- halted  out  1  core is halted.
- mem_err  out  1  sticky data-memory timeout flag.
- stall_cnt  out  CNT_W  total stall cycles, saturating.
- flush_cnt  out  CNT_W  total taken-branch flushes, saturating.

Behaviour:
- State register is 2-bit: RUN=0, MEM_WAIT=1, HALT=2. Value 3 is illegal and goes to HALT.
- Control outputs are combinational from the state and inputs. The state, the wait counter, mem_err and the perf counters are registered.
- Reset (async, immediate): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0. While rst is high, all enables=1, all flushes=0, pc_sel_branch=0, halted=0.
- Condition definitions:
  - mem_stall = exmem_mem_req & ~dmem_ready.
  - load_use = idex_memread & (idex_rd!=0) & ((id_use_rs1 & idex_rd==id_rs1) | (id_use_rs2 & idex_rd==id_rs2)).
- RUN priority, highest first:
  1. mem_stall: all enables=0, memwb_flush=1, other flushes=0. Next state MEM_WAIT, wait_cnt=1, stall_cnt+1.
  2. ex_halt: pc_write=0, ifid_flush=1, idex_flush=1. Next state HALT. A halt takes effect once the older MEM instruction is not stalled.
  3. ex_branch_taken: pc_sel_branch=1, ifid_flush=1, idex_flush=1, flush_cnt+1.
     - The branch wins over a simultaneous load_use; the younger instruction is squashed, so no stall.
  4. load_use: pc_write=0, ifid_write=0, idex_flush=1, stall_cnt+1. Exactly one bubble; the following cycle forwarding supplies the load data.
  5. Otherwise: all enables=1, all flushes=0.
- MEM_WAIT:
  - Outputs are identical to the mem_stall case; EX/ID/IF inputs are ignored while frozen.
  - If dmem_ready=1: this is the release cycle. Enables=1, memwb_flush=0, next state RUN, wait_cnt=0.
    - A branch, halt or load_use pending in the frozen stages is evaluated next cycle in RUN, not in the release cycle.
  - Else if wait_cnt==MEM_TIMEOUT: mem_err<=1 (sticky), next state HALT.
  - Else: wait_cnt+1, stall_cnt+1.
- HALT:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1. EX/MEM and MEM/WB keep draining, with exmem_write=1 and memwb_flush=0.
  - halted=1; all inputs are ignored. Exit is by rst only.
- Counters saturate at 2^CNT_W-1 and never wrap.
- idex_rd==0 never causes a stall. A load with rd=x0 followed by a read of x0 → no stall.
- Reset asserted mid-MEM_WAIT or in HALT aborts to RUN asynchronously; counters and mem_err clear.

Test Plan:
- Load-use: LW x5 in EX (idex_memread=1, idex_rd=5), ID reads rs1=5 → exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1; next cycle all enables=1.
- x0 and unused operand: idex_rd=0 with rs1=0, then idex_rd=7 with rs2=7 and id_use_rs2=0 → no stall in either case; stall_cnt stays 0.
- Branch + load-use in the same cycle: ex_branch_taken=1 and load_use=1 → pc_sel_branch=1, ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- Memory wait: exmem_mem_req=1, dmem_ready low for 3 cycles then high → 3 frozen cycles with memwb_flush=1, release on the 4th; stall_cnt=3, state back to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → mem_err=1 and halted=1 after cycle 5. Inputs are then ignored until rst, which clears mem_err and halted asynchronously.
- Halt and saturation:
  - ex_halt=1 → halted=1 next cycle and pc_write=0 thereafter.
  - With CNT_W=2, 5 load-use stalls → stall_cnt=3.
